cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit requesters; index 0=LSU, 1=MULT, 2=BTU, 3=ALU.
REQ-002 Parameter XLEN, default 32, result data width.
REQ-003 Parameter ROB_TAG_LEN, default 5, ROB tag width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  mispredict squash; discards all held results.
REQ-007 fu_valid  input  NUM_FU  per-FU result-valid request.
REQ-008 fu_tag  input  NUM_FU x ROB_TAG_LEN  per-FU destination ROB tag.
REQ-009 fu_value  input  NUM_FU x XLEN  per-FU result value.
REQ-010 fu_ready  output  NUM_FU  per-FU accept; a result transfers when fu_valid[i] and fu_ready[i] are both 1.
REQ-011 cdb_valid  output  1  broadcast valid this cycle.
REQ-012 cdb_tag  output  ROB_TAG_LEN  broadcast ROB tag.
REQ-013 cdb_value  output  XLEN  broadcast value.
REQ-014 cdb_fu_id  output  clog2(NUM_FU)  index of the granted FU.

Function
REQ-015 One single-entry hold buffer per FU, with fields valid, tag and value.
REQ-016 On a transfer, buffer i loads the tag and value at the edge and its valid bit is set.
REQ-017 fu_ready[i] = !flush && (!buf_valid[i] || grant[i]): the same-cycle grant frees the slot for back-to-back transfers.
REQ-018 Grant rule: round-robin over buf_valid, searching from rr_ptr upward modulo NUM_FU; at most one grant per cycle.
REQ-019 cdb_valid = |buf_valid && !flush. cdb_tag, cdb_value and cdb_fu_id come combinationally from the granted buffer.
REQ-020 When cdb_valid=0, cdb_tag, cdb_value and cdb_fu_id are driven to 0.
REQ-021 Latency: a result transferred at edge k is broadcast no earlier than the cycle after edge k; there is no bypass from fu_* to cdb_*.
REQ-022 Granted buffer: its valid bit clears at the next edge unless the same edge reloads it.
REQ-023 rr_ptr update on a grant: rr_ptr becomes (granted index + 1) mod NUM_FU.
REQ-024 rr_ptr with no grant: it holds its value.
REQ-025 Fairness: with all NUM_FU buffers continuously occupied, each FU is granted exactly once in every NUM_FU consecutive cycles.
REQ-026 Starvation bound: a non-empty buffer is granted within NUM_FU cycles.
REQ-027 Flush cycle: cdb_valid=0, all fu_ready=0, no grant.
REQ-028 Edge after flush: all buf_valid clear and rr_ptr returns to 0.
REQ-029 Wrap-around: the search from rr_ptr=NUM_FU-1 continues at index 0.
REQ-030 Simultaneous events: all FUs may transfer in one cycle; each lands in its own buffer, and there is no loss while ready is honoured.
REQ-031 A held result stays stable (tag and value unchanged) until it is granted or flushed.

Reset
REQ-032 While reset is high, at each edge: buf_valid=0, buf tag/value=0, rr_ptr=0.
REQ-033 Outputs during reset: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_fu_id=0.
REQ-034 During reset, fu_ready is 0.
REQ-035 Reset asserted mid-operation discards all held results with no broadcast; reset has priority over flush and over transfers.

Structure
REQ-036 NUM_FU, the FU index constants (FU_LSU_ID, FU_MULT_ID, FU_BTU_ID, FU_ALU_ID) and the CDB_PACKET typedef (valid, tag, value, fu_id) live in the shared dispatcher/ROB package.
REQ-037 One sub-module, rr_arbiter: a parameterised round-robin grant generator with inputs request vector and rr_ptr and outputs one-hot grant and grant index.

Verification
REQ-038 Single request: fu_valid=4'b1000, tag=5'd7, value=32'hDEAD_BEEF in cycle 0 -> cycle 1: cdb_valid=1, tag=7, value=DEADBEEF, fu_id=3; cycle 2: cdb_valid=0.
REQ-039 All four FUs valid every cycle from reset (rr_ptr=0) -> fu_id sequence 0,1,2,3,0,1...; each fu_ready high exactly in its grant cycle.
REQ-040 Backpressure: MULT held and not granted while fu_valid[1]=1 with a new tag 9 -> fu_ready[1]=0 and the held tag is unchanged; after its grant, tag 9 broadcasts in a later cycle.
REQ-041 Wrap: rr_ptr=3, buffers 0 and 2 full -> grant 0, then grant 2, then cdb_valid=0.
REQ-042 Flush with buffers 1 and 3 full -> that cycle cdb_valid=0; the following cycle cdb_valid=0 with all buffers empty and rr_ptr=0.
REQ-043 Reset asserted while 3 buffers are full -> no broadcast occurs, all outputs are 0, and after deassertion a new single request broadcasts normally.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared dispatcher/ROB definitions: FU count and indices, result widths, and the CDB broadcast packet.
package cdb_arbiter_pkg;

    localparam int NUM_FU      = 4;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam int FU_ID_LEN   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    localparam int FU_LSU_ID  = 0;
    localparam int FU_MULT_ID = 1;
    localparam int FU_BTU_ID  = 2;
    localparam int FU_ALU_ID  = 3;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
        logic [FU_ID_LEN-1:0]   fu_id;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result handshake plus the common data bus broadcast.
// The master side is the FU/ROB environment; the slave side is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU      = cdb_arbiter_pkg::NUM_FU,
    parameter int XLEN        = cdb_arbiter_pkg::XLEN,
    parameter int ROB_TAG_LEN = cdb_arbiter_pkg::ROB_TAG_LEN
);
    localparam int ID_LEN = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic                                  flush;
    logic [NUM_FU-1:0]                     fu_valid;
    logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]    fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]           fu_value;
    logic [NUM_FU-1:0]                     fu_ready;
    logic                                  cdb_valid;
    logic [ROB_TAG_LEN-1:0]                cdb_tag;
    logic [XLEN-1:0]                       cdb_value;
    logic [ID_LEN-1:0]                     cdb_fu_id;

    modport master (
        output flush, fu_valid, fu_tag, fu_value,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu_id
    );

    modport slave (
        input  flush, fu_valid, fu_tag, fu_value,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_fu_id
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin grant generator: first requester at or above ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    import cdb_arbiter_pkg::*;

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr_i) + off) % N);
            if (!found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold buffer per FU, round-robin broadcast of one result per cycle.
// A buffer accepts a new result in the same cycle its current one is granted.
module cdb_arbiter #(
    parameter int NUM_FU      = cdb_arbiter_pkg::NUM_FU,
    parameter int XLEN        = cdb_arbiter_pkg::XLEN,
    parameter int ROB_TAG_LEN = cdb_arbiter_pkg::ROB_TAG_LEN
) (
    input  logic         clk,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    import cdb_arbiter_pkg::*;

    localparam int IDW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]                  bufValid_q, bufValid_d;
    logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] bufTag_q, bufTag_d;
    logic [NUM_FU-1:0][XLEN-1:0]        bufValue_q, bufValue_d;
    logic [IDW-1:0]                     rrPtr_q, rrPtr_d;

    logic [NUM_FU-1:0] arbGrant;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] xfer;
    logic [IDW-1:0]    arbIdx;
    logic              active;

    rr_arbiter #(
        .N  (NUM_FU),
        .IW (IDW)
    ) u_rr_arbiter (
        .req_i (bufValid_q),
        .ptr_i (rrPtr_q),
        .gnt_o (arbGrant),
        .idx_o (arbIdx)
    );

    // Reset and flush both suppress grants, acceptance and the broadcast in the current cycle.
    assign active        = !reset && !bus.flush;
    assign grant         = active ? arbGrant : '0;
    assign bus.fu_ready  = active ? (~bufValid_q | grant) : '0;
    assign xfer          = bus.fu_valid & bus.fu_ready;
    assign bus.cdb_valid = active && (|bufValid_q);

    always_comb begin
        bus.cdb_tag   = '0;
        bus.cdb_value = '0;
        bus.cdb_fu_id = '0;
        if (bus.cdb_valid) begin
            bus.cdb_tag   = bufTag_q[arbIdx];
            bus.cdb_value = bufValue_q[arbIdx];
            bus.cdb_fu_id = arbIdx;
        end
    end

    always_comb begin
        bufValid_d = bufValid_q;
        bufTag_d   = bufTag_q;
        bufValue_d = bufValue_q;
        rrPtr_d    = rrPtr_q;
        if (bus.flush) begin
            bufValid_d = '0;
            rrPtr_d    = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (xfer[i]) begin
                    bufValid_d[i] = 1'b1;
                    bufTag_d[i]   = bus.fu_tag[i];
                    bufValue_d[i] = bus.fu_value[i];
                end else if (grant[i]) begin
                    bufValid_d[i] = 1'b0;
                end
            end
            if (|grant) begin
                rrPtr_d = (arbIdx == IDW'(NUM_FU - 1)) ? '0 : arbIdx + IDW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bufValid_q <= '0;
            bufTag_q   <= '0;
            bufValue_q <= '0;
            rrPtr_q    <= '0;
        end else begin
            bufValid_q <= bufValid_d;
            bufTag_q   <= bufTag_d;
            bufValue_q <= bufValue_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: fixed vector table, directed corner sequences, then random traffic
// against a queue-of-buffers reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] tagVec_t;
    typedef logic [NUM_FU-1:0][XLEN-1:0]        valVec_t;

    typedef struct {
        logic                   r;
        logic                   f;
        logic [NUM_FU-1:0]      v;
        logic [ROB_TAG_LEN-1:0] tagBase;
        logic [XLEN-1:0]        valBase;
        logic                   eValid;
        logic [ROB_TAG_LEN-1:0] eTag;
        logic [XLEN-1:0]        eValue;
        logic [FU_ID_LEN-1:0]   eId;
        logic [NUM_FU-1:0]      eReady;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_LEN(ROB_TAG_LEN)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_LEN(ROB_TAG_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit                     mValid[NUM_FU];
    logic [ROB_TAG_LEN-1:0] mTag[NUM_FU];
    logic [XLEN-1:0]        mVal[NUM_FU];
    int                     mPtr = 0;

    CDB_PACKET         expPkt, gotPkt;
    logic [NUM_FU-1:0] expReady, gotReady;
    vec_t              vecs[15];
    tagVec_t           tv;
    valVec_t           dv;

    task automatic compareField(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // The model keeps one slot per FU and picks the first occupied slot scanning upward from mPtr.
    task automatic modelStep(input logic r, input logic f, input logic [NUM_FU-1:0] v,
                             input tagVec_t t, input valVec_t d);
        int g;
        g        = -1;
        expPkt   = '0;
        expReady = '0;
        if (!r && !f) begin
            for (int off = 0; off < NUM_FU; off++) begin
                int k;
                k = (mPtr + off) % NUM_FU;
                if (g < 0 && mValid[k]) g = k;
            end
            if (g >= 0) begin
                expPkt.valid = 1'b1;
                expPkt.tag   = mTag[g];
                expPkt.value = mVal[g];
                expPkt.fu_id = FU_ID_LEN'(g);
            end
            for (int i = 0; i < NUM_FU; i++) expReady[i] = !mValid[i] || (g == i);
            for (int i = 0; i < NUM_FU; i++) begin
                if (v[i] && expReady[i]) begin
                    mValid[i] = 1'b1;
                    mTag[i]   = t[i];
                    mVal[i]   = d[i];
                end else if (g == i) begin
                    mValid[i] = 1'b0;
                end
            end
            if (g >= 0) mPtr = (g + 1) % NUM_FU;
        end else begin
            for (int i = 0; i < NUM_FU; i++) mValid[i] = 1'b0;
            mPtr = 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic [NUM_FU-1:0] v,
                                 input tagVec_t t, input valVec_t d);
        @(negedge clk);
        reset        = r;
        bus.flush    = f;
        bus.fu_valid = v;
        bus.fu_tag   = t;
        bus.fu_value = d;
        #2;
        gotPkt.valid = bus.cdb_valid;
        gotPkt.tag   = bus.cdb_tag;
        gotPkt.value = bus.cdb_value;
        gotPkt.fu_id = bus.cdb_fu_id;
        gotReady     = bus.fu_ready;
        modelStep(r, f, v, t, d);
    endtask

    task automatic checkOutput(input string name, input CDB_PACKET e, input logic [NUM_FU-1:0] eR);
        compareField({name, ".cdb_valid"}, 64'(gotPkt.valid), 64'(e.valid));
        compareField({name, ".cdb_tag"},   64'(gotPkt.tag),   64'(e.tag));
        compareField({name, ".cdb_value"}, 64'(gotPkt.value), 64'(e.value));
        compareField({name, ".cdb_fu_id"}, 64'(gotPkt.fu_id), 64'(e.fu_id));
        compareField({name, ".fu_ready"},  64'(gotReady),     64'(eR));
    endtask

    task automatic step(input string name, input logic r, input logic f, input logic [NUM_FU-1:0] v,
                        input tagVec_t t, input valVec_t d);
        applyStimulus(r, f, v, t, d);
        checkOutput(name, expPkt, expReady);
    endtask

    initial begin
        CDB_PACKET e;
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_value = '0;
        tv           = '0;
        dv           = '0;

        //            r     f     v        tagB   valBase         eV    eTag   eValue          eId   eReady
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,          2'd0, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 4'b1111, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,          2'd0, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 4'b1000, 5'd4,  32'hDEADBEEC,   1'b0, 5'd0,  32'd0,          2'd0, 4'b1111};
        vecs[3]  = '{1'b0, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b1, 5'd7,  32'hDEADBEEF,   2'd3, 4'b1111};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,          2'd0, 4'b1111};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 5'd8,  32'd100,        1'b0, 5'd0,  32'd0,          2'd0, 4'b1111};
        vecs[6]  = '{1'b0, 1'b0, 4'b1111, 5'd16, 32'd200,        1'b1, 5'd8,  32'd100,        2'd0, 4'b0001};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 5'd24, 32'd300,        1'b1, 5'd9,  32'd101,        2'd1, 4'b0010};
        vecs[8]  = '{1'b0, 1'b0, 4'b1111, 5'd0,  32'd400,        1'b1, 5'd10, 32'd102,        2'd2, 4'b0100};
        vecs[9]  = '{1'b0, 1'b0, 4'b1111, 5'd12, 32'd500,        1'b1, 5'd11, 32'd103,        2'd3, 4'b1000};
        vecs[10] = '{1'b0, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b1, 5'd16, 32'd200,        2'd0, 4'b0001};
        vecs[11] = '{1'b0, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b1, 5'd25, 32'd301,        2'd1, 4'b0011};
        vecs[12] = '{1'b0, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b1, 5'd2,  32'd402,        2'd2, 4'b0111};
        vecs[13] = '{1'b0, 1'b1, 4'b0000, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,          2'd0, 4'b0000};
        vecs[14] = '{1'b0, 1'b0, 4'b0000, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,          2'd0, 4'b1111};

        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                tv[j] = vecs[i].tagBase + ROB_TAG_LEN'(j);
                dv[j] = vecs[i].valBase + XLEN'(j);
            end
            applyStimulus(vecs[i].r, vecs[i].f, vecs[i].v, tv, dv);
            e.valid = vecs[i].eValid;
            e.tag   = vecs[i].eTag;
            e.value = vecs[i].eValue;
            e.fu_id = vecs[i].eId;
            checkOutput($sformatf("vec%0d", i), e, vecs[i].eReady);
        end

        // Backpressure: MULT is held behind LSU, so its new tag 9 must wait.
        tv = '0; dv = '0;
        tv[FU_LSU_ID] = 5'd3; tv[FU_MULT_ID] = 5'd5;
        step("bp_load", 1'b0, 1'b0, 4'b0011, tv, dv);
        tv[FU_MULT_ID] = 5'd9;
        step("bp_hold", 1'b0, 1'b0, 4'b0010, tv, dv);
        compareField("bp_hold.ready1", 64'(gotReady[FU_MULT_ID]), 64'd0);
        compareField("bp_hold.id", 64'(gotPkt.fu_id), 64'(FU_LSU_ID));
        step("bp_grant", 1'b0, 1'b0, 4'b0010, tv, dv);
        compareField("bp_grant.tag", 64'(gotPkt.tag), 64'd5);
        compareField("bp_grant.ready1", 64'(gotReady[FU_MULT_ID]), 64'd1);
        step("bp_new", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("bp_new.tag", 64'(gotPkt.tag), 64'd9);

        // Wrap-around: park the pointer at 3, then fill buffers 0 and 2.
        tv = '0; tv[FU_BTU_ID] = 5'd20;
        step("wr_load2", 1'b0, 1'b0, 4'b0100, tv, dv);
        step("wr_grant2", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("wr_grant2.id", 64'(gotPkt.fu_id), 64'd2);
        tv[FU_LSU_ID] = 5'd21; tv[FU_BTU_ID] = 5'd22;
        step("wr_load02", 1'b0, 1'b0, 4'b0101, tv, dv);
        step("wr_g0", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("wr_g0.id", 64'(gotPkt.fu_id), 64'd0);
        compareField("wr_g0.tag", 64'(gotPkt.tag), 64'd21);
        step("wr_g2", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("wr_g2.id", 64'(gotPkt.fu_id), 64'd2);
        step("wr_idle", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("wr_idle.valid", 64'(gotPkt.valid), 64'd0);

        // Flush with buffers 1 and 3 occupied; pointer was left at 3.
        tv = '0; tv[FU_MULT_ID] = 5'd1; tv[FU_ALU_ID] = 5'd3;
        step("fl_load", 1'b0, 1'b0, 4'b1010, tv, dv);
        step("fl_flush", 1'b0, 1'b1, 4'b1111, tv, dv);
        compareField("fl_flush.valid", 64'(gotPkt.valid), 64'd0);
        compareField("fl_flush.ready", 64'(gotReady), 64'd0);
        step("fl_after", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("fl_after.valid", 64'(gotPkt.valid), 64'd0);
        compareField("fl_after.ready", 64'(gotReady), 64'hF);
        step("fl_fill", 1'b0, 1'b0, 4'b1111, tv, dv);
        step("fl_ptr0", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("fl_ptr0.id", 64'(gotPkt.fu_id), 64'd0);
        for (int i = 0; i < 3; i++) step("fl_drain", 1'b0, 1'b0, 4'b0000, tv, dv);

        // Reset mid-operation with three buffers full.
        tv = '0; tv[0] = 5'd4; tv[1] = 5'd5; tv[2] = 5'd6;
        step("rs_load", 1'b0, 1'b0, 4'b0111, tv, dv);
        step("rs_on", 1'b1, 1'b0, 4'b1111, tv, dv);
        compareField("rs_on.valid", 64'(gotPkt.valid), 64'd0);
        compareField("rs_on.ready", 64'(gotReady), 64'd0);
        step("rs_on2", 1'b1, 1'b0, 4'b0000, tv, dv);
        step("rs_off", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("rs_off.valid", 64'(gotPkt.valid), 64'd0);
        tv[FU_BTU_ID] = 5'd30; dv[FU_BTU_ID] = 32'hCAFE_F00D;
        step("rs_req", 1'b0, 1'b0, 4'b0100, tv, dv);
        step("rs_bcast", 1'b0, 1'b0, 4'b0000, tv, dv);
        compareField("rs_bcast.tag", 64'(gotPkt.tag), 64'd30);
        compareField("rs_bcast.value", 64'(gotPkt.value), 64'hCAFE_F00D);

        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                tv[j] = ROB_TAG_LEN'($urandom);
                dv[j] = XLEN'($urandom);
            end
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                 NUM_FU'($urandom), tv, dv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
